// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer:
// FSM state encoding, opcode map, strobe bundle and small helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seqStateT;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_ALU0 = 4'h4;
  localparam logic [3:0] OP_ALU1 = 4'h5;
  localparam logic [3:0] OP_ALU2 = 4'h6;
  localparam logic [3:0] OP_ALU3 = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZA  = 4'hA;
  localparam logic [3:0] OP_JEQ  = 4'hB;
  localparam logic [3:0] OP_JGT  = 4'hC;
  localparam logic [3:0] OP_JLT  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  localparam int FETCH_LAT_MIN = 1;
  localparam int FETCH_LAT_MAX = 7;

  typedef struct packed {
    logic loadIR;
    logic loadPC;
    logic incPC;
    logic loadA;
    logic loadB;
    logic loadC;
    logic weDM;
    logic mode;
    logic selA;
    logic selB;
  } strobeT;

  function automatic logic isAluOp(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

  // Whether a control-transfer opcode redirects the PC for the given ALU flags.
  function automatic logic branchTaken(input logic [3:0] op, input logic za,
                                       input logic eq, input logic gt, input logic lt);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JZA:  t = za;
      OP_JEQ:  t = eq;
      OP_JGT:  t = gt;
      OP_JLT:  t = lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic int clampLat(input int lat);
    if (lat < FETCH_LAT_MIN) return FETCH_LAT_MIN;
    if (lat > FETCH_LAT_MAX) return FETCH_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Datapath-facing bundle of the sequencer: instruction/flag inputs and
// the strobes and mux selects driven into the datapath.
interface cpu_sequencer_if;

  logic [3:0] opcode;
  logic       za;
  logic       eq;
  logic       gt;
  logic       lt;
  logic       loadIR;
  logic       loadPC;
  logic       incPC;
  logic       loadA;
  logic       loadB;
  logic       loadC;
  logic       we_DM;
  logic       mode;
  logic       selA;
  logic       selB;

  modport master (
    input  opcode, za, eq, gt, lt,
    output loadIR, loadPC, incPC, loadA, loadB, loadC, we_DM, mode, selA, selB
  );

  modport slave (
    output opcode, za, eq, gt, lt,
    input  loadIR, loadPC, incPC, loadA, loadB, loadC, we_DM, mode, selA, selB
  );

endinterface

// File: rtl/seq_decode.sv
// Combinational map from (state, opcode, branch decision) to the strobe
// bundle that must be visible while the FSM sits in that state.
module seq_decode
  import cpu_pkg::*;
(
  input  seqStateT   state,
  input  logic [3:0] opcode,
  input  logic       take,
  input  logic       fetchLast,
  input  logic       bootIdle,
  output strobeT     strobes
);

  always_comb begin
    strobes = '0;
    case (state)
      ST_IDLE:   strobes.selB = bootIdle;
      ST_FETCH:  strobes.loadIR = fetchLast;
      ST_DECODE: ;
      ST_EXEC: begin
        case (opcode)
          OP_LDA: strobes.loadA = 1'b1;
          OP_LDB: strobes.loadB = 1'b1;
          OP_LDI: begin
            strobes.selA  = 1'b0;
            strobes.loadC = 1'b1;
          end
          OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3: begin
            strobes.mode = 1'b1;
            strobes.selA = 1'b1;
          end
          OP_ST:  strobes.weDM = 1'b1;
          default: ;
        endcase
      end
      ST_WB: begin
        if (isAluOp(opcode)) begin
          strobes.mode  = 1'b1;
          strobes.selA  = 1'b1;
          strobes.loadC = 1'b1;
        end
        // Exactly one of loadPC/incPC per retired instruction.
        if (opcode == OP_JMP || take) strobes.loadPC = 1'b1;
        else                          strobes.incPC  = 1'b1;
      end
      ST_HALT: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller. Strobes are registered from
// the next state so they line up with the state they belong to.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 step_mode,
  cpu_sequencer_if.master      dp,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  localparam int         LAT_C      = clampLat(FETCH_LAT);
  localparam logic [2:0] FETCH_LAST = 3'(LAT_C - 1);

  localparam strobeT RESET_STROBES = '{selB: 1'b1, default: 1'b0};

  seqStateT         stateReg, stateNext;
  logic [2:0]       fetchCntReg, fetchCntNext;
  logic             takeReg, takeNext;
  logic             bootIdleReg, bootIdleNext;
  logic             takeNow;
  logic             fetchLast;
  strobeT           strobeReg, strobeNext;
  logic             illegalReg;
  logic [CNT_W-1:0] retiredReg;

  assign takeNow = branchTaken(dp.opcode, dp.za, dp.eq, dp.gt, dp.lt);

  always_comb begin
    stateNext    = stateReg;
    fetchCntNext = fetchCntReg;
    takeNext     = takeReg;
    bootIdleNext = bootIdleReg;
    case (stateReg)
      ST_IDLE: begin
        if (start) begin
          stateNext    = ST_FETCH;
          fetchCntNext = FETCH_LAST;
          bootIdleNext = 1'b0;
        end
      end
      ST_FETCH: begin
        if (fetchCntReg == 3'd0) stateNext = ST_DECODE;
        else                     fetchCntNext = fetchCntReg - 3'd1;
      end
      // HALT is recognised as soon as the opcode settles, skipping EXEC.
      ST_DECODE: stateNext = (dp.opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        takeNext  = takeNow;
        stateNext = (dp.opcode == OP_HALT) ? ST_HALT : ST_WB;
      end
      ST_WB: begin
        if (step_mode) begin
          stateNext = ST_IDLE;
        end else begin
          stateNext    = ST_FETCH;
          fetchCntNext = FETCH_LAST;
        end
      end
      ST_HALT: stateNext = ST_HALT;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign fetchLast = (stateNext == ST_FETCH) && (fetchCntNext == 3'd0);

  seq_decode uDecode (
    .state     (stateNext),
    .opcode    (dp.opcode),
    .take      (takeNext),
    .fetchLast (fetchLast),
    .bootIdle  (bootIdleNext),
    .strobes   (strobeNext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg    <= ST_IDLE;
      fetchCntReg <= 3'd0;
      takeReg     <= 1'b0;
      bootIdleReg <= 1'b1;
      strobeReg   <= RESET_STROBES;
      illegalReg  <= 1'b0;
      retiredReg  <= '0;
    end else if (en) begin
      stateReg    <= stateNext;
      fetchCntReg <= fetchCntNext;
      takeReg     <= takeNext;
      bootIdleReg <= bootIdleNext;
      strobeReg   <= strobeNext;
      if (stateReg == ST_WB)
        retiredReg <= retiredReg + CNT_W'(1);
      if (stateReg == ST_EXEC && dp.opcode == OP_RSVD)
        illegalReg <= 1'b1;
    end
  end

  // A stalled cycle must never write the datapath; the held strobes replay when en returns.
  assign dp.loadIR = strobeReg.loadIR & en;
  assign dp.loadPC = strobeReg.loadPC & en;
  assign dp.incPC  = strobeReg.incPC  & en;
  assign dp.loadA  = strobeReg.loadA  & en;
  assign dp.loadB  = strobeReg.loadB  & en;
  assign dp.loadC  = strobeReg.loadC  & en;
  assign dp.we_DM  = strobeReg.weDM   & en;
  assign dp.mode   = strobeReg.mode;
  assign dp.selA   = strobeReg.selA;
  assign dp.selB   = strobeReg.selB;

  assign busy    = (stateReg != ST_IDLE) && (stateReg != ST_HALT);
  assign halted  = (stateReg == ST_HALT);
  assign illegal = illegalReg;
  assign retired = retiredReg;

endmodule
